// File: rtl/mobile_tx_pkg.sv
// ============================================================================
//  Module      : mobile_tx_pkg
//  Description : Shared types and constants for the mobile transmitter:
//                handshake FSM state encoding, error bit indices and
//                default FIFO depth / handshake timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mobile_tx_pkg;

    // Handshake FSM states; each byte walks SETUP -> REQ -> REL.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP_HI = 3'd1,
        REQ_HI   = 3'd2,
        REL_HI   = 3'd3,
        SETUP_LO = 3'd4,
        REQ_LO   = 3'd5,
        REL_LO   = 3'd6
    } tx_state_t;

    // Bit positions inside the sticky error register.
    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_OVF     = 1;

    // Default build parameters.
    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_TIMEOUT = 65535;

endpackage : mobile_tx_pkg

`default_nettype wire

// File: rtl/tx_fifo.sv
// ============================================================================
//  Module      : tx_fifo
//  Description : Small synchronous FIFO with first-word-fall-through read
//                data, registered full/empty flags and an occupancy count.
//                Writes while full and reads while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_next;
    logic             wr_ok;
    logic             rd_ok;

    // Qualify requests against the flags as they stand before the edge.
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage array; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, count and registered flags; pointers wrap as DEPTH is 2^n.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == FULL_COUNT);
            empty <= (count_next == '0);
        end
    end

endmodule : tx_fifo

`default_nettype wire

// File: rtl/mobile_transmitter.sv
// ============================================================================
//  Module      : mobile_transmitter
//  Description : Sends CPU-written 16-bit words to the phone interface as two
//                bytes (high first) over an 8-bit bus with a four-phase
//                req/ack handshake. Words are buffered in a small FIFO; every
//                handshake wait is bounded by a timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mobile_transmitter
    import mobile_tx_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        err_clr,
    input  logic        tx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_req,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic [1:0]  err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    tx_state_t              state;
    tx_state_t              state_next;
    logic                   ack_meta;
    logic                   ack_s;
    logic [TW-1:0]          timer;
    logic [7:0]             word_lo;
    logic [15:0]            fifo_rd_data;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   have_word;
    logic                   pop;
    logic                   load_hi;
    logic                   load_lo;
    logic                   timeout_evt;
    logic                   expired;
    logic [1:0]             err_set;

    tx_fifo #(
        .DEPTH   (DEPTH),
        .WIDTH   (16)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign have_word = (fifo_count != '0);
    assign expired   = (timer == TIMER_LAST);

    // Two-flop synchroniser for the peer's asynchronous acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= tx_ack;
            ack_s    <= ack_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; a completed handshake beats the timeout.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        load_hi     = 1'b0;
        load_lo     = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            IDLE: begin
                // A peer still holding ack must release it before a new word.
                if (have_word && !ack_s) begin
                    pop        = 1'b1;
                    load_hi    = 1'b1;
                    state_next = SETUP_HI;
                end
            end
            SETUP_HI: state_next = REQ_HI;
            REQ_HI: begin
                if (ack_s) begin
                    state_next = REL_HI;
                end else if (expired) begin
                    timeout_evt = 1'b1;
                    state_next  = IDLE;
                end
            end
            REL_HI: begin
                if (!ack_s) begin
                    load_lo    = 1'b1;
                    state_next = SETUP_LO;
                end else if (expired) begin
                    timeout_evt = 1'b1;
                    state_next  = IDLE;
                end
            end
            SETUP_LO: state_next = REQ_LO;
            REQ_LO: begin
                if (ack_s) begin
                    state_next = REL_LO;
                end else if (expired) begin
                    timeout_evt = 1'b1;
                    state_next  = IDLE;
                end
            end
            REL_LO: begin
                if (!ack_s) begin
                    state_next = IDLE;
                end else if (expired) begin
                    timeout_evt = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-state dwell counter; restarts on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (state_next != state || state == IDLE) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Byte lane: high byte on pop, low byte once the high handshake closes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_data <= '0;
            word_lo <= '0;
        end else if (load_hi) begin
            tx_data <= fifo_rd_data[15:8];
            word_lo <= fifo_rd_data[7:0];
        end else if (load_lo) begin
            tx_data <= word_lo;
        end
    end

    // Registered request and busy, decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_req <= 1'b0;
            busy   <= 1'b0;
        end else begin
            tx_req <= (state_next == REQ_HI) || (state_next == REQ_LO);
            busy   <= (state_next != IDLE);
        end
    end

    // Error events raised this cycle.
    always_comb begin
        err_set              = '0;
        err_set[ERR_TIMEOUT] = timeout_evt;
        err_set[ERR_OVF]     = wr_en && full;
    end

    // Sticky error register; a new event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= '0;
        end else begin
            err <= (err & ~{2{err_clr}}) | err_set;
        end
    end

endmodule : mobile_transmitter

`default_nettype wire

// File: tb/tb_mobile_transmitter.sv
// ============================================================================
//  Module      : tb_mobile_transmitter
//  Description : Directed self-checking bench for mobile_transmitter with a
//                behavioural req/ack responder and a byte monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mobile_transmitter;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        err_clr;
    logic        tx_ack;
    logic [7:0]  tx_data;
    logic        tx_req;
    logic        full;
    logic        empty;
    logic        busy;
    logic [1:0]  err;

    int          checks;
    int          failures;
    int          mode;       // 0: never ack, 1: ack/release after 3 cycles, 2: ack stuck high
    int          resp_cnt;
    logic        req_q;
    logic [7:0]  bytes [$];
    logic [15:0] words [0:7];

    mobile_transmitter #(
        .DEPTH   (4),
        .TIMEOUT (20)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .err_clr (err_clr),
        .tx_ack  (tx_ack),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .full    (full),
        .empty   (empty),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Peer model: follows tx_req with a 3-cycle lag in mode 1.
    initial begin
        tx_ack   = 1'b0;
        resp_cnt = 0;
        forever begin
            @(negedge clk);
            case (mode)
                1: begin
                    if (tx_req != tx_ack) resp_cnt++;
                    else resp_cnt = 0;
                    if (resp_cnt >= 3) begin
                        tx_ack   = tx_req;
                        resp_cnt = 0;
                    end
                end
                2:       tx_ack = 1'b1;
                default: tx_ack = 1'b0;
            endcase
        end
    end

    // Byte monitor: records tx_data at every rising edge of tx_req.
    initial begin
        req_q = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_req && !req_q) bytes.push_back(tx_data);
            req_q = tx_req;
        end
    end

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = words[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drained(input int limit, input string tag);
        int n;
        n = 0;
        while (!(empty && !busy) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, {30'd0, empty, busy}, 32'h2);
    endtask

    task automatic wait_req(input logic level, input int limit, input string tag);
        int n;
        n = 0;
        while (tx_req !== level && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, {31'd0, tx_req}, {31'd0, level});
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        mode     = 0;
        rst      = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        err_clr  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_data", {24'd0, tx_data}, 32'h0);
        check("rst_tx_req",  {31'd0, tx_req},  32'h0);
        check("rst_full",    {31'd0, full},    32'h0);
        check("rst_empty",   {31'd0, empty},   32'h1);
        check("rst_busy",    {31'd0, busy},    32'h0);
        check("rst_err",     {30'd0, err},     32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single word with start-latency checks
        mode = 1;
        bytes.delete();
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 16'hA55A;
        @(posedge clk); #1;
        check("lat_empty_n",  {31'd0, empty}, 32'h0);
        check("lat_busy_n",   {31'd0, busy},  32'h0);
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk); #1;
        check("lat_data_n1",  {24'd0, tx_data}, 32'hA5);
        check("lat_busy_n1",  {31'd0, busy},    32'h1);
        check("lat_empty_n1", {31'd0, empty},   32'h1);
        check("lat_req_n1",   {31'd0, tx_req},  32'h0);
        @(posedge clk); #1;
        check("lat_req_n2",   {31'd0, tx_req},  32'h1);
        wait_drained(200, "single_drain");
        check("single_nbytes", bytes.size(), 32'd2);
        if (bytes.size() == 2) begin
            check("single_hi", {24'd0, bytes[0]}, 32'hA5);
            check("single_lo", {24'd0, bytes[1]}, 32'h5A);
        end
        check("single_tx_data_hold", {24'd0, tx_data}, 32'h5A);
        check("single_err", {30'd0, err}, 32'h0);

        // Overflow: six writes while the peer is silent
        mode = 0;
        bytes.delete();
        for (int i = 0; i < 6; i++) words[i] = {8'(2*i+1), 8'(2*i+2)};
        write_n(6);
        check("ovf_full", {31'd0, full}, 32'h1);
        check("ovf_err",  {30'd0, err},  32'h2);
        mode = 1;
        wait_drained(1000, "ovf_drain");
        check("ovf_nbytes", bytes.size(), 32'd10);
        if (bytes.size() == 10) begin
            for (int i = 0; i < 10; i++) check("ovf_byte", {24'd0, bytes[i]}, 32'(i + 1));
        end
        check("ovf_err_kept", {30'd0, err}, 32'h2);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("ovf_err_clr", {30'd0, err}, 32'h0);

        // Timeout in REQ_HI, then next word
        mode = 0;
        bytes.delete();
        words[0] = 16'hBEEF;
        words[1] = 16'hCAFE;
        write_n(2);
        wait_req(1'b1, 20, "to_req_rise");
        n = 0;
        while (tx_req && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check("to_req_len", n, 32'd20);
        check("to_err", {30'd0, err}, 32'h1);
        wait_req(1'b1, 10, "to_next_rise");
        check("to_next_data", {24'd0, tx_data}, 32'hCA);
        @(negedge clk);
        err_clr = 1'b1;
        wr_en   = 1'b1;
        wr_data = 16'h1234;
        @(negedge clk);
        err_clr = 1'b0;
        wr_en   = 1'b0;
        check("to_err_clr", {30'd0, err}, 32'h0);

        // Stuck ack: REL_HI times out, IDLE waits for ack release
        mode = 2;
        n = 0;
        while (!(busy == 1'b0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("stuck_idle", {31'd0, busy}, 32'h0);
        check("stuck_err",  {30'd0, err},  32'h1);
        repeat (5) @(posedge clk);
        #1;
        check("stuck_busy",  {31'd0, busy},   32'h0);
        check("stuck_empty", {31'd0, empty},  32'h0);
        check("stuck_req",   {31'd0, tx_req}, 32'h0);
        mode = 1;
        wait_drained(200, "stuck_drain");
        check("stuck_nbytes", bytes.size(), 32'd4);
        if (bytes.size() == 4) begin
            check("stuck_b0", {24'd0, bytes[0]}, 32'hBE);
            check("stuck_b1", {24'd0, bytes[1]}, 32'hCA);
            check("stuck_b2", {24'd0, bytes[2]}, 32'h12);
            check("stuck_b3", {24'd0, bytes[3]}, 32'h34);
        end

        // Reset during REQ_LO
        bytes.delete();
        words[0] = 16'h5678;
        words[1] = 16'h9ABC;
        write_n(2);
        n = 0;
        while (!(tx_req && tx_data == 8'h78) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("rmid_reach_lo", {31'd0, (tx_req && tx_data == 8'h78)}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("rmid_req_drop", {31'd0, tx_req}, 32'h0);
        check("rmid_busy",     {31'd0, busy},   32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rmid_empty",   {31'd0, empty},   32'h1);
        check("rmid_tx_data", {24'd0, tx_data}, 32'h0);
        repeat (30) @(posedge clk);
        #1;
        check("rmid_no_req",  bytes.size(), 32'd2);

        // Clear/set collision on an overflow write
        mode = 0;
        for (int i = 0; i < 5; i++) words[i] = 16'h1000 + 16'(i);
        write_n(5);
        check("coll_full", {31'd0, full}, 32'h1);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 16'hFFFF;
        err_clr = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        err_clr = 1'b0;
        check("coll_err_ovf", {31'd0, err[1]}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mobile_transmitter

`default_nettype wire
